// File: rtl/rtc_arbitro_pkg.sv
// rtl/rtc_arbitro_pkg.sv - shared types and constants for the RTC arbiter
// Contents: FSM state encoding, refresh sweep addresses, parameter defaults,
//           helper mapping a sweep index to its RTC register address.
package rtc_arbitro_pkg;

  typedef enum logic [2:0] {
    REPOSO   = 3'd0,
    ESCRIBE  = 3'd1,
    LEE      = 3'd2,
    REFRESCO = 3'd3,
    PAUSA    = 3'd4
  } estado_t;

  localparam logic [7:0] DIR_SEG  = 8'h21;
  localparam logic [7:0] DIR_MIN  = 8'h22;
  localparam logic [7:0] DIR_HORA = 8'h23;

  localparam int PERIODO_REFRESCO_DEF = 100000;
  localparam int TIMEOUT_DEF          = 255;

  // Sweep order is seconds, minutes, hours.
  function automatic logic [7:0] dir_refresco(input logic [1:0] idx);
    case (idx)
      2'd0:    dir_refresco = DIR_SEG;
      2'd1:    dir_refresco = DIR_MIN;
      default: dir_refresco = DIR_HORA;
    endcase
  endfunction

endpackage

// File: rtl/rtc_temporizador.sv
// rtl/rtc_temporizador.sv - free-running refresh period timer
// Ports: clk, reset (async active-low), en (count enable),
//        tick (one-cycle pulse on the last count of each period).
module rtc_temporizador
  import rtc_arbitro_pkg::*;
#(
  parameter int PERIODO = PERIODO_REFRESCO_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIODO > 1) ? $clog2(PERIODO) : 1;

  logic [CW-1:0] cuenta;

  assign tick = en && (cuenta == CW'(PERIODO - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta <= '0;
    end else if (en) begin
      if (tick) cuenta <= '0;
      else      cuenta <= cuenta + CW'(1);
    end
  end

endmodule

// File: rtl/rtc_arbitro.sv
// rtl/rtc_arbitro.sv - arbiter between write, read and periodic time refresh
// Ports: clk, reset (async active-low);
//        req_esc/dir_esc/dato_esc -> ack_esc        (write requester)
//        req_lee/dir_lee -> ack_lee/dato_lee_out    (read requester)
//        esc_iniciar/esc_dir/esc_dato <- esc_final  (write engine)
//        lee_iniciar/lee_dir <- lee_final/lee_dato  (read engine)
//        seg/min/hora, refresco_ok                  (refreshed time)
//        error                                      (timeout abort pulse)
module rtc_arbitro
  import rtc_arbitro_pkg::*;
#(
  parameter int PERIODO_REFRESCO = PERIODO_REFRESCO_DEF,
  parameter int TIMEOUT          = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_esc,
  input  logic [7:0] dir_esc,
  input  logic [7:0] dato_esc,
  input  logic       req_lee,
  input  logic [7:0] dir_lee,
  output logic       ack_esc,
  output logic       ack_lee,
  output logic [7:0] dato_lee_out,
  output logic       esc_iniciar,
  output logic [7:0] esc_dir,
  output logic [7:0] esc_dato,
  input  logic       esc_final,
  output logic       lee_iniciar,
  output logic [7:0] lee_dir,
  input  logic       lee_final,
  input  logic [7:0] lee_dato,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic       refresco_ok,
  output logic       error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  estado_t       estado, estado_sig;
  logic          tick;
  logic          refresco_pend;
  logic          ult_esc;        // last grant went to the writer
  logic [7:0]    dir_esc_q, dato_esc_q, dir_lee_q;
  logic [TW-1:0] cuenta_to;
  logic          vencido;
  logic [1:0]    idx;            // refresh sweep position
  logic          hueco;          // idle cycle between sweep reads
  logic [7:0]    seg_tmp, min_tmp;

  rtc_temporizador #(
    .PERIODO (PERIODO_REFRESCO)
  ) u_temporizador (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .tick  (tick)
  );

  assign vencido = (cuenta_to == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO: begin
        // A pending sweep overtakes requests right after a write so a
        // busy writer cannot starve the time refresh.
        if (refresco_pend && ult_esc) estado_sig = REFRESCO;
        else if (req_esc)             estado_sig = ESCRIBE;
        else if (req_lee)             estado_sig = LEE;
        else if (refresco_pend)       estado_sig = REFRESCO;
      end
      ESCRIBE:  if (esc_final || vencido) estado_sig = PAUSA;
      LEE:      if (lee_final || vencido) estado_sig = PAUSA;
      REFRESCO: if (!hueco && (lee_final ? (idx == 2'd2) : vencido)) estado_sig = PAUSA;
      PAUSA:    estado_sig = REPOSO;
      default:  estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    esc_iniciar = 1'b0;
    esc_dir     = '0;
    esc_dato    = '0;
    lee_iniciar = 1'b0;
    lee_dir     = '0;
    case (estado)
      ESCRIBE: begin
        esc_iniciar = 1'b1;
        esc_dir     = dir_esc_q;
        esc_dato    = dato_esc_q;
      end
      LEE: begin
        lee_iniciar = 1'b1;
        lee_dir     = dir_lee_q;
      end
      REFRESCO: begin
        lee_iniciar = !hueco;
        lee_dir     = dir_refresco(idx);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresco_pend <= 1'b0;
      ult_esc       <= 1'b0;
      dir_esc_q     <= '0;
      dato_esc_q    <= '0;
      dir_lee_q     <= '0;
      cuenta_to     <= '0;
      idx           <= '0;
      hueco         <= 1'b0;
      seg_tmp       <= '0;
      min_tmp       <= '0;
      seg           <= '0;
      min           <= '0;
      hora          <= '0;
      dato_lee_out  <= '0;
      ack_esc       <= 1'b0;
      ack_lee       <= 1'b0;
      refresco_ok   <= 1'b0;
      error         <= 1'b0;
    end else begin
      ack_esc     <= 1'b0;
      ack_lee     <= 1'b0;
      refresco_ok <= 1'b0;
      error       <= 1'b0;

      // Setting an already-set flag is a no-op, so a wrap during a pending
      // sweep never queues a second one. Completion below overrides this.
      if (tick) refresco_pend <= 1'b1;

      case (estado)
        REPOSO: begin
          cuenta_to <= '0;
          idx       <= '0;
          hueco     <= 1'b0;
          case (estado_sig)
            ESCRIBE: begin
              dir_esc_q  <= dir_esc;
              dato_esc_q <= dato_esc;
              ult_esc    <= 1'b1;
            end
            LEE: begin
              dir_lee_q <= dir_lee;
              ult_esc   <= 1'b0;
            end
            REFRESCO: ult_esc <= 1'b0;
            default: ;
          endcase
        end
        ESCRIBE: begin
          if (esc_final)    ack_esc   <= 1'b1;
          else if (vencido) error     <= 1'b1;
          else              cuenta_to <= cuenta_to + TW'(1);
        end
        LEE: begin
          if (lee_final) begin
            dato_lee_out <= lee_dato;
            ack_lee      <= 1'b1;
          end else if (vencido) begin
            error <= 1'b1;
          end else begin
            cuenta_to <= cuenta_to + TW'(1);
          end
        end
        REFRESCO: begin
          if (hueco) begin
            hueco     <= 1'b0;
            cuenta_to <= '0;
          end else if (lee_final) begin
            // Seconds and minutes stay in shadow registers so an aborted
            // sweep never leaves a half-updated time.
            case (idx)
              2'd0: seg_tmp <= lee_dato;
              2'd1: min_tmp <= lee_dato;
              default: begin
                seg           <= seg_tmp;
                min           <= min_tmp;
                hora          <= lee_dato;
                refresco_ok   <= 1'b1;
                refresco_pend <= 1'b0;
              end
            endcase
            if (idx != 2'd2) begin
              idx       <= idx + 2'd1;
              hueco     <= 1'b1;
              cuenta_to <= '0;
            end
          end else if (vencido) begin
            error <= 1'b1;
          end else begin
            cuenta_to <= cuenta_to + TW'(1);
          end
        end
        PAUSA:   cuenta_to <= '0;
        default: cuenta_to <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_arbitro.sv
// tb/tb_rtc_arbitro.sv - directed scoreboard bench for rtc_arbitro
module tb_rtc_arbitro;
  import rtc_arbitro_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_esc, req_lee;
  logic [7:0] dir_esc, dato_esc, dir_lee;
  logic       ack_esc, ack_lee;
  logic [7:0] dato_lee_out;
  logic       esc_iniciar, lee_iniciar;
  logic [7:0] esc_dir, esc_dato, lee_dir;
  logic       esc_final = 1'b0;
  logic       lee_final = 1'b0;
  logic [7:0] lee_dato  = 8'h00;
  logic [7:0] seg, min, hora;
  logic       refresco_ok, error;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [256];
  bit         esc_en  = 1'b1;
  int         esc_lat = 3;
  int         lee_lat = 2;
  int         e_cnt = 0;
  int         l_cnt = 0;

  typedef struct packed {
    logic [1:0] tipo;   // 0 write ack, 1 read ack, 2 error
    logic [7:0] dato;
  } esp_t;
  esp_t sb[$];

  rtc_arbitro #(
    .PERIODO_REFRESCO (50),
    .TIMEOUT          (10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_esc      (req_esc),
    .dir_esc      (dir_esc),
    .dato_esc     (dato_esc),
    .req_lee      (req_lee),
    .dir_lee      (dir_lee),
    .ack_esc      (ack_esc),
    .ack_lee      (ack_lee),
    .dato_lee_out (dato_lee_out),
    .esc_iniciar  (esc_iniciar),
    .esc_dir      (esc_dir),
    .esc_dato     (esc_dato),
    .esc_final    (esc_final),
    .lee_iniciar  (lee_iniciar),
    .lee_dir      (lee_dir),
    .lee_final    (lee_final),
    .lee_dato     (lee_dato),
    .seg          (seg),
    .min          (min),
    .hora         (hora),
    .refresco_ok  (refresco_ok),
    .error        (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] salidas();
    return {2'b00, ack_esc, ack_lee, dato_lee_out, esc_iniciar, esc_dir, esc_dato,
            lee_iniciar, lee_dir, seg, min, hora, refresco_ok, error};
  endfunction

  // Engine models: final after a fixed number of iniciar-high cycles.
  always @(negedge clk) begin
    if (esc_iniciar) begin
      e_cnt     = e_cnt + 1;
      esc_final = esc_en && (e_cnt == esc_lat);
    end else begin
      e_cnt     = 0;
      esc_final = 1'b0;
    end
    if (lee_iniciar) begin
      l_cnt     = l_cnt + 1;
      lee_final = (l_cnt == lee_lat);
      lee_dato  = lee_final ? mem[lee_dir] : 8'h00;
    end else begin
      l_cnt     = 0;
      lee_final = 1'b0;
      lee_dato  = 8'h00;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (reset) begin
      check("un_iniciar", 64'(esc_iniciar & lee_iniciar), 64'd0);
      if (ack_esc || ack_lee || error) begin
        if (sb.size() == 0) begin
          check("evento_inesperado", 64'({ack_esc, ack_lee, error}), 64'd0);
        end else begin
          esp_t e;
          logic [1:0] t;
          e = sb.pop_front();
          t = ack_esc ? 2'd0 : (ack_lee ? 2'd1 : 2'd2);
          check("sb_tipo", 64'(t), 64'(e.tipo));
          if (e.tipo == 2'd1) check("sb_dato_lee", 64'(dato_lee_out), 64'(e.dato));
        end
      end
      if (refresco_ok)
        check("sb_refresco", 64'({hora, min, seg}), 64'({mem[8'h23], mem[8'h22], mem[8'h21]}));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, ciclos, bajos, nz;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h21] = 8'h30;
    mem[8'h22] = 8'h15;
    mem[8'h23] = 8'h09;
    reset = 1'b0; req_esc = 1'b0; req_lee = 1'b0;
    dir_esc = 8'h00; dato_esc = 8'h00; dir_lee = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_salidas", salidas(), 64'd0);
    check("reset_estado", 64'(dut.estado), 64'(REPOSO));
    reset = 1'b1;

    // T1: single write, inputs change and request drops after grant
    @(negedge clk);
    dir_esc = 8'h21; dato_esc = 8'h45; req_esc = 1'b1;
    sb.push_back(esp_t'{2'd0, 8'h00});
    n = 0;
    while (!esc_iniciar && n < 10) begin @(negedge clk); n++; end
    check("t1_inicio", 64'(esc_iniciar), 64'd1);
    req_esc = 1'b0; dir_esc = 8'hFF; dato_esc = 8'h00;
    ciclos = 0;
    while (esc_iniciar && ciclos < 20) begin
      check("t1_dir_dato", 64'({esc_dir, esc_dato}), 64'h2145);
      if (ciclos == 1) begin dir_lee = 8'h50; req_lee = 1'b1; end
      if (ciclos == 2) req_lee = 1'b0;
      ciclos++;
      @(negedge clk);
    end
    check("t1_ciclos_iniciar", 64'(ciclos), 64'd3);
    check("t1_ack", 64'(ack_esc), 64'd1);
    check("t1_pausa", 64'(dut.estado), 64'(PAUSA));
    @(negedge clk);
    check("t1_ack_pulso", 64'(ack_esc), 64'd0);
    check("t1_reposo", 64'(dut.estado), 64'(REPOSO));
    repeat (2) @(negedge clk);
    check("t1_lee_ignorada", 64'(lee_iniciar), 64'd0);

    // T2: simultaneous write and read, write first
    dir_esc = 8'h10; dato_esc = 8'h77; dir_lee = 8'h40;
    req_esc = 1'b1; req_lee = 1'b1;
    sb.push_back(esp_t'{2'd0, 8'h00});
    sb.push_back(esp_t'{2'd1, mem[8'h40]});
    n = 0;
    while (!esc_iniciar && n < 10) begin @(negedge clk); n++; end
    check("t2_esc_primero", 64'({esc_iniciar, lee_iniciar}), 64'b10);
    req_esc = 1'b0;
    n = 0;
    while (!ack_esc && n < 20) begin @(negedge clk); n++; end
    check("t2_ack_esc", 64'(ack_esc), 64'd1);
    n = 0;
    while (!lee_iniciar && n < 10) begin @(negedge clk); n++; end
    check("t2_lee_dir", 64'({lee_iniciar, lee_dir}), 64'h140);
    req_lee = 1'b0;
    n = 0;
    while (!ack_lee && n < 20) begin @(negedge clk); n++; end
    check("t2_ack_lee", 64'({ack_lee, dato_lee_out}), 64'({1'b1, mem[8'h40]}));
    @(negedge clk);
    check("t2_dato_retenido", 64'({ack_lee, dato_lee_out}), 64'({1'b0, mem[8'h40]}));

    // T3: refresh sweep
    n = 0;
    while (!(lee_iniciar && lee_dir == 8'h21) && n < 100) begin @(negedge clk); n++; end
    check("t3_inicio", 64'({lee_iniciar, lee_dir}), 64'h121);
    for (int k = 0; k < 3; k++) begin
      ciclos = 0;
      while (lee_iniciar && ciclos < 20) begin
        check("t3_dir", 64'(lee_dir), 64'(8'h21 + k));
        ciclos++;
        @(negedge clk);
      end
      check("t3_ciclos", 64'(ciclos), 64'(lee_lat));
      if (k < 2) begin
        if (k == 0) check("t3_sin_parcial", 64'({hora, min, seg}), 64'd0);
        bajos = 0;
        while (!lee_iniciar && bajos < 5) begin bajos++; @(negedge clk); end
        check("t3_hueco", 64'(bajos), 64'd1);
      end
    end
    check("t3_ok", 64'(refresco_ok), 64'd1);
    check("t3_tiempo", 64'({hora, min, seg}), 64'h091530);
    @(negedge clk);
    check("t3_ok_pulso", 64'(refresco_ok), 64'd0);

    // T4: write timeout
    esc_en = 1'b0;
    dir_esc = 8'h55; dato_esc = 8'h66; req_esc = 1'b1;
    sb.push_back(esp_t'{2'd2, 8'h00});
    n = 0;
    while (!esc_iniciar && n < 10) begin @(negedge clk); n++; end
    check("t4_inicio", 64'(esc_iniciar), 64'd1);
    n = 0;
    while (!error && n < 30) begin @(negedge clk); n++; end
    req_esc = 1'b0;
    check("t4_latencia", 64'(n), 64'd10);
    check("t4_sin_ack", 64'({esc_iniciar, ack_esc}), 64'd0);
    check("t4_pausa", 64'(dut.estado), 64'(PAUSA));
    @(negedge clk);
    check("t4_reposo", 64'({error, 3'(dut.estado)}), 64'(REPOSO));
    esc_en = 1'b1;

    // T5: reset during second sweep read
    mem[8'h21] = 8'h31;
    n = 0;
    while (!(lee_iniciar && lee_dir == 8'h22) && n < 150) begin @(negedge clk); n++; end
    check("t5_segunda_lectura", 64'({lee_iniciar, lee_dir}), 64'h122);
    reset = 1'b0;
    #1;
    check("t5_salidas_cero", salidas(), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0; nz = 0;
    while (!refresco_ok && n < 120) begin
      if ({hora, min, seg} != 24'd0) nz++;
      @(negedge clk);
      n++;
    end
    check("t5_sin_actualizacion", 64'(nz), 64'd0);
    check("t5_barrido", 64'({refresco_ok, hora, min, seg}), 64'h1091531);

    repeat (2) @(negedge clk);
    check("sb_vacio", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
